dll_coarse_tap_ctrl: RTL

Sequential controller that produces the 3-bit coarse delay-tap select (q) and the 4-bit acquisition progress count (count) for the downstream 3-to-8 tap decoder in the DLL.
It runs a 3-step successive-approximation (SAR) search driven by phase-detector up/dn decisions, then an up/down tracking phase that declares lock after a set number of direction reversals.
The downstream decoder honours q only while count <= 2 and parks on the centre tap otherwise, so count semantics are fixed and must hold exactly.

---
 rtl/dll_coarse_tap_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/dll_coarse_tap_ctrl.sv
// Coarse DLL tap controller: 3-step SAR search on phase-detector decisions,
// then up/down tracking until enough direction reversals declare lock.
module dll_coarse_tap_ctrl #(
   parameter int SETTLE_CYC = 4,
   parameter int LOCK_REV   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pd_valid,
   input  logic       up,
   input  logic       dn,
   output logic [2:0] q,
   output logic [3:0] count,
   output logic       busy,
   output logic       locked
);

   typedef enum logic [1:0] {S_IDLE, S_SAR, S_TRACK, S_LOCKED} state_t;
   typedef enum logic [1:0] {DIR_NONE, DIR_INC, DIR_DEC} dir_t;

   localparam logic [3:0] SETTLE = 4'(SETTLE_CYC);
   localparam logic [3:0] REV_LOCK = 4'(LOCK_REV);

   state_t     r_state;
   dir_t       r_last;
   logic [1:0] r_bit;
   logic [3:0] r_settle;
   logic [3:0] r_rev;

   logic       w_inc, w_dec, w_accept, w_rev;
   logic [2:0] w_sar_q;
   logic [3:0] w_rev_next, w_rev_count;

   assign w_inc    = up & ~dn;
   assign w_dec    = dn & ~up;
   assign w_accept = pd_valid && (r_settle == 4'd0);
   assign w_rev    = (w_inc && r_last == DIR_DEC) || (w_dec && r_last == DIR_INC);

   assign w_rev_next  = (r_rev == 4'd15) ? 4'd15 : r_rev + 4'd1;
   assign w_rev_count = (w_rev_next > 4'd12) ? 4'd15 : w_rev_next + 4'd3;

   // Trial value for the current SAR bit: DEC drops it, the next lower bit is tried.
   always_comb begin
      w_sar_q = q;
      if (w_dec) w_sar_q[r_bit] = 1'b0;
      if (r_bit != 2'd0) w_sar_q[r_bit - 2'd1] = 1'b1;
   end

   // NOTE: reset is sampled only on the clock edge and every state register
   // uses non-blocking assignment, so all branches see the pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_last   <= DIR_NONE;
         r_bit    <= 2'd2;
         r_settle <= 4'd0;
         r_rev    <= 4'd0;
         q        <= 3'd4;
         count    <= 4'd0;
         busy     <= 1'b0;
         locked   <= 1'b0;
      end else if (start) begin
         r_state  <= S_SAR;
         r_last   <= DIR_NONE;
         r_bit    <= 2'd2;
         r_settle <= SETTLE;
         r_rev    <= 4'd0;
         q        <= 3'b100;
         count    <= 4'd0;
         busy     <= 1'b1;
         locked   <= 1'b0;
      end else begin
         if (r_settle != 4'd0) r_settle <= r_settle - 4'd1;
         case (r_state)
            S_SAR: begin
               if (w_accept) begin
                  q        <= w_sar_q;
                  count    <= count + 4'd1;
                  r_settle <= SETTLE;
                  if (r_bit == 2'd0) r_state <= S_TRACK;
                  else r_bit <= r_bit - 2'd1;
               end
            end
            S_TRACK: begin
               if (r_rev >= REV_LOCK) begin
                  r_state <= S_LOCKED;
                  locked  <= 1'b1;
                  busy    <= 1'b0;
               end else if (w_accept && (w_inc || w_dec)) begin
                  r_last <= w_inc ? DIR_INC : DIR_DEC;
                  // Saturated moves leave q alone and must not restart settling.
                  if (w_inc && q != 3'd7) begin
                     q        <= q + 3'd1;
                     r_settle <= SETTLE;
                  end
                  if (w_dec && q != 3'd0) begin
                     q        <= q - 3'd1;
                     r_settle <= SETTLE;
                  end
                  if (w_rev) begin
                     r_rev <= w_rev_next;
                     count <= w_rev_count;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
